sti_deserializer: RTL and testbench
===================================

// Module: sti_deserializer
// PURPOSE
//  Serial-to-parallel receiver for the STI single-bit stream (data/valid pair).
//  Collects 8/16/24/32-bit frames and strips padding to recover the 16-bit payload.
//  Delivers each payload word through a 2-entry valid/ready output buffer.
//  Sits at the far end of the STI serial link, where received data returns to parallel form.
// PARAMETERS
//  GAP_TIMEOUT  16  consecutive idle cycles mid-frame that abort the frame (>=2)
//  FCNT_W       8   width of the delivered-frame counter
// PORTS
//  clk         in   1       clock; all state changes on the rising edge
//  reset       in   1       asynchronous, active-low reset
//  si_data     in   1       serial bit, sampled when si_valid=1
//  si_valid    in   1       serial bit qualifier; gaps allowed inside a frame
//  cfg_length  in   2       frame size: 0=8, 1=16, 2=24, 3=32 bits
//  cfg_msb     in   1       1: first bit received is frame bit N-1; 0: first bit is bit 0
//  cfg_fill    in   1       len 2/3 only: 1=payload in upper 16 frame bits, 0=lower 16
//  cfg_low     in   1       len 0 only: 1=byte goes to po_data[15:8], 0=po_data[7:0]
//  err_clr     in   1       clears ovr_err and tmo_err
//  po_ready    in   1       consumer accepts the head entry when po_valid=1
//  po_data     out  16      head payload word
//  po_pad_err  out  1       head entry had a nonzero padding bit (len 2/3)
//  po_valid    out  1       buffer non-empty
//  ovr_err     out  1       sticky: a completed frame was dropped because the buffer was full
//  tmo_err     out  1       sticky: a frame was aborted by the gap timeout
//  frame_cnt   out  FCNT_W  frames delivered (pushed); wraps modulo 2^FCNT_W
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; buffer empty; bit counter and gap counter 0.
//   Reset asserted mid-frame discards the partial frame without raising any flag.
//  FSM IDLE: si_valid=1 latches cfg_* and shifts in bit 0 of the frame -> SHIFT.
//   cfg_* changes during SHIFT are ignored until the next frame.
//  FSM SHIFT: each si_valid=1 shifts one bit and clears the gap counter.
//   Each si_valid=0 increments the gap counter.
//   Gap counter reaching GAP_TIMEOUT -> tmo_err<=1, frame discarded, FSM -> IDLE.
//  Completion: on the edge accepting bit N-1 (N=8*(cfg_length+1)), FSM -> IDLE.
//   If si_valid=1 on the next cycle, a new frame starts then; back-to-back frames carry no dead cycle.
//  Frame word W[N-1:0]: with msb=1 the k-th received bit (k=0..N-1) lands at W[N-1-k]; with msb=0 at W[k].
//  Payload extraction:
//   len0: cfg_low ? {W[7:0],8'h00} : {8'h00,W[7:0]}
//   len1: W[15:0]
//   len2/3: cfg_fill ? W[N-1:N-16] : W[15:0]
//  po_pad_err: OR of all frame bits outside the payload field (len 2/3 only); 0 for len 0/1.
//  Push: {payload, pad_err} written on the completion edge.
//   po_valid is registered: high the cycle after completion when the buffer was empty.
//   Latency from last-bit edge to po_valid is 1 cycle.
//  Pop: the head is removed on an edge where po_valid & po_ready.
//  Full (2 entries) at completion with no pop on that edge: frame dropped, ovr_err<=1,
//   frame_cnt unchanged.
//  Full with a pop on the same edge: push accepted, no overrun.
//  frame_cnt increments on each accepted push; it wraps from all-ones to 0.
//  err_clr has priority over a same-cycle set: ovr_err/tmo_err <= 0.
//  po_data and po_pad_err hold steady while po_valid=1 and po_ready=0.
// TESTING
//  1 len1 msb=1, 16 bits of 16'hA55A MSB-first -> po_data=16'hA55A, po_valid 1 cycle after bit 15.
//  2 len0 msb=0 low=1, byte 8'h3C LSB-first with random si_valid gaps <16 -> po_data=16'h3C00.
//  3 len3 msb=1 fill=0, 16 zeros then 16'h1234 -> 16'h1234, po_pad_err=0;
//    repeat with a pad bit=1 -> po_pad_err=1.
//  4 po_ready=0, three back-to-back len1 frames -> 2 buffered, ovr_err=1, frame_cnt=2;
//    then pop both and check FIFO order.
//  5 five bits, then si_valid=0 for GAP_TIMEOUT cycles -> tmo_err=1, no push;
//    the next full frame is received correctly.
//  6 reset low mid-frame -> all outputs 0; the following frame decodes correctly;
//    err_clr clears both sticky flags.

Source files
------------

// File: rtl/sti_deserializer.sv
// STI serial receiver: collects 8/16/24/32-bit frames from a data/valid bit stream,
// recovers the 16-bit payload and delivers it through a 2-entry valid/ready buffer.
module sti_deserializer #(
    parameter int GAP_TIMEOUT = 16,
    parameter int FCNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              si_data,
    input  logic              si_valid,
    input  logic [1:0]        cfg_length,
    input  logic              cfg_msb,
    input  logic              cfg_fill,
    input  logic              cfg_low,
    input  logic              err_clr,
    input  logic              po_ready,
    output logic [15:0]       po_data,
    output logic              po_pad_err,
    output logic              po_valid,
    output logic              ovr_err,
    output logic              tmo_err,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic [0:0]        dbg_state
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;
    localparam int         GAP_W    = $clog2(GAP_TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);

    // Handshake: an entry leaves the buffer on a rising edge where po_valid and
    // po_ready are both 1; po_data/po_pad_err hold while po_valid=1 and po_ready=0.

    logic [0:0]        r_state;
    logic [4:0]        r_bit_cnt;
    logic [31:0]       r_raw;
    logic [GAP_W-1:0]  r_gap;
    logic [1:0]        r_len;
    logic              r_msb;
    logic              r_fill;
    logic              r_low;

    logic [15:0]       r_mem_data [2];
    logic              r_mem_pad  [2];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_count;
    logic              r_ovr;
    logic              r_tmo;
    logic [FCNT_W-1:0] r_fcnt;

    logic [4:0]        w_last_idx;
    logic              w_complete;
    logic              w_timeout;
    logic [31:0]       w_raw;
    logic [31:0]       w_frame;
    logic [15:0]       w_payload;
    logic              w_pad;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    // Index of the final bit of the frame: 8*(len+1)-1.
    assign w_last_idx = {r_len, 3'b111};
    assign w_complete = (r_state == ST_SHIFT) && si_valid && (r_bit_cnt == w_last_idx);
    assign w_timeout  = (r_state == ST_SHIFT) && !si_valid && (r_gap == GAP_LAST);

    // r_raw keeps bits in arrival order; the incoming bit is merged in here so the
    // completion edge can use the full frame without an extra register stage.
    always_comb begin
        w_raw            = r_raw;
        w_raw[r_bit_cnt] = si_data;
    end

    always_comb begin
        w_frame = '0;
        for (int i = 0; i < 32; i++) begin
            if (5'(i) <= w_last_idx) begin
                w_frame[i] = r_msb ? w_raw[5'(w_last_idx - 5'(i))] : w_raw[i];
            end
        end
    end

    always_comb begin
        w_payload = '0;
        w_pad     = 1'b0;
        case (r_len)
            2'd0: w_payload = r_low ? {w_frame[7:0], 8'h00} : {8'h00, w_frame[7:0]};
            2'd1: w_payload = w_frame[15:0];
            2'd2: begin
                w_payload = r_fill ? w_frame[23:8] : w_frame[15:0];
                w_pad     = r_fill ? |w_frame[7:0] : |w_frame[23:16];
            end
            default: begin
                w_payload = r_fill ? w_frame[31:16] : w_frame[15:0];
                w_pad     = r_fill ? |w_frame[15:0] : |w_frame[31:16];
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_raw     <= '0;
            r_gap     <= '0;
            r_len     <= '0;
            r_msb     <= 1'b0;
            r_fill    <= 1'b0;
            r_low     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (si_valid) begin
                        r_len     <= cfg_length;
                        r_msb     <= cfg_msb;
                        r_fill    <= cfg_fill;
                        r_low     <= cfg_low;
                        r_raw     <= {31'b0, si_data};
                        r_bit_cnt <= 5'd1;
                        r_gap     <= '0;
                        r_state   <= ST_SHIFT;
                    end
                end
                default: begin
                    if (si_valid) begin
                        r_raw <= w_raw;
                        r_gap <= '0;
                        if (w_complete) begin
                            r_bit_cnt <= '0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end else if (w_timeout) begin
                        r_gap     <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
            endcase
        end
    end

    // A pop on the completion edge frees a slot, so a full buffer still accepts.
    assign w_pop  = (r_count != 2'd0) && po_ready;
    assign w_push = w_complete && ((r_count != 2'd2) || w_pop);
    assign w_drop = w_complete && (r_count == 2'd2) && !w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_data[0] <= '0;
            r_mem_data[1] <= '0;
            r_mem_pad[0]  <= 1'b0;
            r_mem_pad[1]  <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_count       <= '0;
            r_fcnt        <= '0;
        end else begin
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= w_payload;
                r_mem_pad[r_wr_ptr]  <= w_pad;
                r_wr_ptr             <= ~r_wr_ptr;
                r_fcnt               <= r_fcnt + FCNT_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Clearing wins over a flag raised on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovr <= 1'b0;
            r_tmo <= 1'b0;
        end else if (err_clr) begin
            r_ovr <= 1'b0;
            r_tmo <= 1'b0;
        end else begin
            if (w_drop) begin
                r_ovr <= 1'b1;
            end
            if (w_timeout) begin
                r_tmo <= 1'b1;
            end
        end
    end

    assign po_data    = r_mem_data[r_rd_ptr];
    assign po_pad_err = r_mem_pad[r_rd_ptr];
    assign po_valid   = (r_count != 2'd0);
    assign ovr_err    = r_ovr;
    assign tmo_err    = r_tmo;
    assign frame_cnt  = r_fcnt;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_sti_deserializer.sv
// Bench for sti_deserializer: directed scenarios plus randomized frames checked
// against a payload model computed from the frame value and a queue of expected words.
module tb_sti_deserializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        si_data;
    logic        si_valid;
    logic [1:0]  cfg_length;
    logic        cfg_msb;
    logic        cfg_fill;
    logic        cfg_low;
    logic        err_clr;
    logic        po_ready;
    logic [15:0] po_data;
    logic        po_pad_err;
    logic        po_valid;
    logic        ovr_err;
    logic        tmo_err;
    logic [7:0]  frame_cnt;
    logic [0:0]  dbg_state;

    int          checks = 0;
    int          fails  = 0;
    logic [16:0] exp_q[$];
    logic [7:0]  exp_fcnt = 8'd0;
    logic        exp_ovr  = 1'b0;

    sti_deserializer #(.GAP_TIMEOUT(16), .FCNT_W(8)) dut (
        .clk(clk), .reset(reset), .si_data(si_data), .si_valid(si_valid),
        .cfg_length(cfg_length), .cfg_msb(cfg_msb), .cfg_fill(cfg_fill), .cfg_low(cfg_low),
        .err_clr(err_clr), .po_ready(po_ready), .po_data(po_data), .po_pad_err(po_pad_err),
        .po_valid(po_valid), .ovr_err(ovr_err), .tmo_err(tmo_err), .frame_cnt(frame_cnt),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after each rising edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input bit b, input int gap);
        repeat (gap) begin
            si_valid = 1'b0;
            step();
        end
        si_valid = 1'b1;
        si_data  = b;
        step();
        si_valid = 1'b0;
        si_data  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] w, input int len, input bit msb, input bit fill,
                              input bit low, input int maxgap, input bit scramble);
        int n;
        n          = 8 * (len + 1);
        cfg_length = 2'(len);
        cfg_msb    = msb;
        cfg_fill   = fill;
        cfg_low    = low;
        for (int k = 0; k < n; k++) begin
            drive_bit(msb ? w[n-1-k] : w[k], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            if (k == 0 && scramble) begin
                cfg_length = 2'($urandom_range(0, 3));
                cfg_msb    = 1'($urandom_range(0, 1));
                cfg_fill   = 1'($urandom_range(0, 1));
                cfg_low    = 1'($urandom_range(0, 1));
            end
        end
    endtask

    function automatic logic [16:0] model_word(input logic [31:0] w, input int len,
                                               input bit fill, input bit low);
        longint v;
        longint p;
        bit     pad;
        int     n;
        v = longint'(w);
        n = 8 * (len + 1);
        if (len == 0) begin
            p   = low ? (v % 256) * 256 : v % 256;
            pad = 1'b0;
        end else if (len == 1) begin
            p   = v % 65536;
            pad = 1'b0;
        end else if (fill) begin
            p   = v >> (n - 16);
            pad = (v % (longint'(1) << (n - 16))) != 0;
        end else begin
            p   = v % 65536;
            pad = (v >> 16) != 0;
        end
        return {p[15:0], pad};
    endfunction

    // Scoreboard update for a frame completed while nothing is being popped.
    task automatic expect_frame(input logic [31:0] w, input int len, input bit fill, input bit low);
        if (exp_q.size() < 2) begin
            exp_q.push_back(model_word(w, len, fill, low));
            exp_fcnt = exp_fcnt + 8'd1;
        end else begin
            exp_ovr = 1'b1;
        end
    endtask

    function automatic logic [31:0] rand_frame(input int len);
        int n;
        n = 8 * (len + 1);
        return 32'(longint'($urandom()) % (longint'(1) << n));
    endfunction

    task automatic test_reset();
        reset = 1'b0; si_data = 1'b0; si_valid = 1'b0; cfg_length = 2'd0; cfg_msb = 1'b0;
        cfg_fill = 1'b0; cfg_low = 1'b0; err_clr = 1'b0; po_ready = 1'b0;
        repeat (3) step();
        checks++; if (po_valid !== 1'b0) begin fails++; $display("FAIL reset_po_valid: got %0h expected 0", po_valid); end
        checks++; if (po_data !== 16'h0) begin fails++; $display("FAIL reset_po_data: got %h expected 0000", po_data); end
        checks++; if (po_pad_err !== 1'b0) begin fails++; $display("FAIL reset_pad: got %0h expected 0", po_pad_err); end
        checks++; if (ovr_err !== 1'b0) begin fails++; $display("FAIL reset_ovr: got %0h expected 0", ovr_err); end
        checks++; if (tmo_err !== 1'b0) begin fails++; $display("FAIL reset_tmo: got %0h expected 0", tmo_err); end
        checks++; if (frame_cnt !== 8'h0) begin fails++; $display("FAIL reset_fcnt: got %0d expected 0", frame_cnt); end
        checks++; if (dbg_state !== 1'b0) begin fails++; $display("FAIL reset_state: got %0h expected 0", dbg_state); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_len1_msb();
        logic [15:0] w;
        w = 16'hA55A;
        cfg_length = 2'd1; cfg_msb = 1'b1; cfg_fill = 1'b0; cfg_low = 1'b0;
        for (int k = 0; k < 16; k++) begin
            drive_bit(w[15-k], 0);
            if (k == 14) begin
                checks++; if (po_valid !== 1'b0) begin fails++; $display("FAIL len1_early_valid: got %0h expected 0", po_valid); end
            end
        end
        exp_fcnt = exp_fcnt + 8'd1;
        checks++; if (po_valid !== 1'b1) begin fails++; $display("FAIL len1_valid: got %0h expected 1", po_valid); end
        checks++; if (po_data !== 16'hA55A) begin fails++; $display("FAIL len1_data: got %h expected a55a", po_data); end
        checks++; if (po_pad_err !== 1'b0) begin fails++; $display("FAIL len1_pad: got %0h expected 0", po_pad_err); end
        checks++; if (frame_cnt !== exp_fcnt) begin fails++; $display("FAIL len1_fcnt: got %0d expected %0d", frame_cnt, exp_fcnt); end
        step();
        checks++; if (po_data !== 16'hA55A) begin fails++; $display("FAIL len1_hold: got %h expected a55a", po_data); end
        po_ready = 1'b1;
        step();
        po_ready = 1'b0;
        checks++; if (po_valid !== 1'b0) begin fails++; $display("FAIL len1_pop: got %0h expected 0", po_valid); end
    endtask

    task automatic test_len0_gaps();
        send_frame(32'h3C, 0, 1'b0, 1'b0, 1'b1, 15, 1'b0);
        exp_fcnt = exp_fcnt + 8'd1;
        checks++; if (po_valid !== 1'b1) begin fails++; $display("FAIL len0_valid: got %0h expected 1", po_valid); end
        checks++; if (po_data !== 16'h3C00) begin fails++; $display("FAIL len0_data: got %h expected 3c00", po_data); end
        checks++; if (tmo_err !== 1'b0) begin fails++; $display("FAIL len0_tmo: got %0h expected 0", tmo_err); end
        po_ready = 1'b1; step(); po_ready = 1'b0;
    endtask

    task automatic test_len3_pad();
        send_frame(32'h0000_1234, 3, 1'b1, 1'b0, 1'b0, 3, 1'b1);
        exp_fcnt = exp_fcnt + 8'd1;
        checks++; if (po_data !== 16'h1234) begin fails++; $display("FAIL len3_data: got %h expected 1234", po_data); end
        checks++; if (po_pad_err !== 1'b0) begin fails++; $display("FAIL len3_pad0: got %0h expected 0", po_pad_err); end
        po_ready = 1'b1; step(); po_ready = 1'b0;
        send_frame(32'h0100_1234, 3, 1'b1, 1'b0, 1'b0, 3, 1'b1);
        exp_fcnt = exp_fcnt + 8'd1;
        checks++; if (po_data !== 16'h1234) begin fails++; $display("FAIL len3_data2: got %h expected 1234", po_data); end
        checks++; if (po_pad_err !== 1'b1) begin fails++; $display("FAIL len3_pad1: got %0h expected 1", po_pad_err); end
        checks++; if (frame_cnt !== exp_fcnt) begin fails++; $display("FAIL len3_fcnt: got %0d expected %0d", frame_cnt, exp_fcnt); end
        po_ready = 1'b1; step(); po_ready = 1'b0;
    endtask

    task automatic test_overrun();
        logic [31:0] w;
        logic [16:0] e;
        logic [7:0]  base;
        base = exp_fcnt;
        po_ready = 1'b0;
        for (int f = 0; f < 3; f++) begin
            w = rand_frame(1);
            send_frame(w, 1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, 1'b0);
            expect_frame(w, 1, 1'b0, 1'b0);
        end
        checks++; if (ovr_err !== 1'b1) begin fails++; $display("FAIL ovr_set: got %0h expected 1", ovr_err); end
        checks++; if (frame_cnt !== base + 8'd2) begin fails++; $display("FAIL ovr_fcnt: got %0d expected %0d", frame_cnt, base + 8'd2); end
        for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front();
            checks++; if ({po_valid, po_data, po_pad_err} !== {1'b1, e}) begin fails++; $display("FAIL ovr_order%0d: got %0h/%h expected 1/%h", p, po_valid, po_data, e[16:1]); end
            po_ready = 1'b1; step(); po_ready = 1'b0;
        end
        checks++; if (po_valid !== 1'b0) begin fails++; $display("FAIL ovr_empty: got %0h expected 0", po_valid); end
        err_clr = 1'b1; step(); err_clr = 1'b0;
        exp_ovr = 1'b0;
        checks++; if (ovr_err !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %0h expected 0", ovr_err); end
    endtask

    task automatic test_pop_push_same_edge();
        logic [31:0] w;
        logic [16:0] e;
        for (int f = 0; f < 2; f++) begin
            w = rand_frame(1);
            send_frame(w, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
            expect_frame(w, 1, 1'b0, 1'b0);
        end
        w = rand_frame(1);
        cfg_length = 2'd1; cfg_msb = 1'b0;
        for (int k = 0; k < 15; k++) drive_bit(w[k], 0);
        e = exp_q.pop_front();
        checks++; if ({po_data, po_pad_err} !== e) begin fails++; $display("FAIL same_head: got %h expected %h", po_data, e[16:1]); end
        po_ready = 1'b1;
        drive_bit(w[15], 0);
        po_ready = 1'b0;
        expect_frame(w, 1, 1'b0, 1'b0);
        checks++; if (ovr_err !== 1'b0) begin fails++; $display("FAIL same_ovr: got %0h expected 0", ovr_err); end
        checks++; if (frame_cnt !== exp_fcnt) begin fails++; $display("FAIL same_fcnt: got %0d expected %0d", frame_cnt, exp_fcnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if ({po_valid, po_data, po_pad_err} !== {1'b1, e}) begin fails++; $display("FAIL same_drain: got %0h/%h expected 1/%h", po_valid, po_data, e[16:1]); end
            po_ready = 1'b1; step(); po_ready = 1'b0;
        end
    endtask

    task automatic test_timeout();
        logic [31:0] w;
        logic [16:0] e;
        cfg_length = 2'd1; cfg_msb = 1'b1;
        for (int k = 0; k < 5; k++) drive_bit(1'($urandom_range(0, 1)), 0);
        repeat (15) step();
        checks++; if (tmo_err !== 1'b0) begin fails++; $display("FAIL tmo_early: got %0h expected 0", tmo_err); end
        step();
        checks++; if (tmo_err !== 1'b1) begin fails++; $display("FAIL tmo_set: got %0h expected 1", tmo_err); end
        checks++; if (po_valid !== 1'b0) begin fails++; $display("FAIL tmo_nopush: got %0h expected 0", po_valid); end
        checks++; if (frame_cnt !== exp_fcnt) begin fails++; $display("FAIL tmo_fcnt: got %0d expected %0d", frame_cnt, exp_fcnt); end
        w = rand_frame(2);
        send_frame(w, 2, 1'b1, 1'b1, 1'b0, 2, 1'b1);
        expect_frame(w, 2, 1'b1, 1'b0);
        e = exp_q.pop_front();
        checks++; if ({po_valid, po_data, po_pad_err} !== {1'b1, e}) begin fails++; $display("FAIL tmo_next: got %0h/%h/%0h expected 1/%h/%0h", po_valid, po_data, po_pad_err, e[16:1], e[0]); end
        po_ready = 1'b1; step(); po_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        logic [16:0] e;
        cfg_length = 2'd1; cfg_msb = 1'b0;
        for (int k = 0; k < 10; k++) drive_bit(1'($urandom_range(0, 1)), 0);
        reset = 1'b0;
        #2;
        checks++; if ({po_valid, po_data, po_pad_err, ovr_err, tmo_err, frame_cnt} !== 27'h0) begin fails++; $display("FAIL rstmid_outputs: got %0h/%h/%0h/%0h/%0h/%0d expected all 0", po_valid, po_data, po_pad_err, ovr_err, tmo_err, frame_cnt); end
        step();
        reset = 1'b1;
        step();
        exp_q.delete(); exp_fcnt = 8'd0; exp_ovr = 1'b0;
        w = rand_frame(1);
        send_frame(w, 1, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        expect_frame(w, 1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++; if ({po_valid, po_data, po_pad_err} !== {1'b1, e}) begin fails++; $display("FAIL rstmid_next: got %0h/%h expected 1/%h", po_valid, po_data, e[16:1]); end
        checks++; if (frame_cnt !== 8'd1) begin fails++; $display("FAIL rstmid_fcnt: got %0d expected 1", frame_cnt); end
        po_ready = 1'b1; step(); po_ready = 1'b0;
    endtask

    task automatic test_err_clr();
        logic [31:0] w;
        logic [16:0] e;
        cfg_length = 2'd0;
        for (int k = 0; k < 3; k++) drive_bit(1'b1, 0);
        repeat (16) step();
        for (int f = 0; f < 3; f++) begin
            w = rand_frame(0);
            send_frame(w, 0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
            expect_frame(w, 0, 1'b0, 1'b1);
        end
        checks++; if ({ovr_err, tmo_err} !== 2'b11) begin fails++; $display("FAIL errs_set: got %0h%0h expected 11", ovr_err, tmo_err); end
        err_clr = 1'b1; step(); err_clr = 1'b0;
        exp_ovr = 1'b0;
        checks++; if ({ovr_err, tmo_err} !== 2'b00) begin fails++; $display("FAIL errs_clear: got %0h%0h expected 00", ovr_err, tmo_err); end
        cfg_length = 2'd1;
        for (int k = 0; k < 2; k++) drive_bit(1'b0, 0);
        repeat (15) step();
        err_clr = 1'b1; step(); err_clr = 1'b0;
        step();
        checks++; if (tmo_err !== 1'b0) begin fails++; $display("FAIL clr_priority: got %0h expected 0", tmo_err); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if ({po_valid, po_data, po_pad_err} !== {1'b1, e}) begin fails++; $display("FAIL clr_drain: got %0h/%h expected 1/%h", po_valid, po_data, e[16:1]); end
            po_ready = 1'b1; step(); po_ready = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [16:0] e;
        int len, npop;
        bit msb, fill, low;
        for (int it = 0; it < 40; it++) begin
            len  = int'($urandom_range(0, 3));
            msb  = 1'($urandom_range(0, 1));
            fill = 1'($urandom_range(0, 1));
            low  = 1'($urandom_range(0, 1));
            w    = rand_frame(len);
            send_frame(w, len, msb, fill, low, int'($urandom_range(0, 3)), 1'b1);
            expect_frame(w, len, fill, low);
            checks++; if (ovr_err !== exp_ovr) begin fails++; $display("FAIL rnd_ovr%0d: got %0h expected %0h", it, ovr_err, exp_ovr); end
            checks++; if (frame_cnt !== exp_fcnt) begin fails++; $display("FAIL rnd_fcnt%0d: got %0d expected %0d", it, frame_cnt, exp_fcnt); end
            npop = int'($urandom_range(0, exp_q.size()));
            for (int p = 0; p < npop; p++) begin
                e = exp_q.pop_front();
                checks++; if ({po_valid, po_data, po_pad_err} !== {1'b1, e}) begin fails++; $display("FAIL rnd_data%0d: got %0h/%h/%0h expected 1/%h/%0h", it, po_valid, po_data, po_pad_err, e[16:1], e[0]); end
                po_ready = 1'b1; step(); po_ready = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
                err_clr = 1'b1; step(); err_clr = 1'b0;
                exp_ovr = 1'b0;
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if ({po_valid, po_data, po_pad_err} !== {1'b1, e}) begin fails++; $display("FAIL rnd_drain: got %0h/%h expected 1/%h", po_valid, po_data, e[16:1]); end
            po_ready = 1'b1; step(); po_ready = 1'b0;
        end
    endtask

    task automatic test_wrap();
        int nframes;
        nframes = 256 - int'(exp_fcnt) + 3;
        po_ready = 1'b1;
        for (int f = 0; f < nframes; f++) begin
            send_frame(rand_frame(0), 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
            exp_fcnt = exp_fcnt + 8'd1;
            if (exp_fcnt < 8'd4) begin
                checks++; if (frame_cnt !== exp_fcnt) begin fails++; $display("FAIL wrap_fcnt: got %0d expected %0d", frame_cnt, exp_fcnt); end
            end
        end
        step();
        po_ready = 1'b0;
        checks++; if (po_valid !== 1'b0) begin fails++; $display("FAIL wrap_empty: got %0h expected 0", po_valid); end
        checks++; if (ovr_err !== 1'b0) begin fails++; $display("FAIL wrap_ovr: got %0h expected 0", ovr_err); end
    endtask

    initial begin
        test_reset();
        test_len1_msb();
        test_len0_gaps();
        test_len3_pad();
        test_overrun();
        test_pop_push_same_edge();
        test_timeout();
        test_reset_mid();
        test_err_clr();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
